// File: rtl/ip_fixer_pkg.sv
// Shared definitions for the ip_fixer result producer: parser state encoding,
// header field constants and the ones'-complement adder.
package ip_fixer_pkg;

    typedef enum logic [5:0] {
        MOD_HDR  = 6'b000001,
        W1       = 6'b000010,
        W2       = 6'b000100,
        W3       = 6'b001000,
        W4       = 6'b010000,
        WAIT_EOP = 6'b100000
    } state_t;

    localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
    localparam logic [3:0]  IP_VERSION4  = 4'd4;

    localparam int BYTE_LEN_LSB  = 0;
    localparam int ETHERTYPE_LSB = 16;
    localparam int VERSION_LSB   = 12;
    localparam int IP_LEN_LSB    = 48;
    localparam int IP_CSUM_LSB   = 48;
    localparam int DST_IP_LO_LSB = 48;

    // 16-bit ones'-complement add with end-around carry.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry.
// A write while full is accepted only when a read frees a slot in the same cycle.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 33,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      do_wr, do_rd;

    assign empty = (count == '0);
    assign full  = (count == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            if (do_wr && !do_rd)
                count <= count + (MAX_DEPTH_BITS+1)'(1);
            else if (do_rd && !do_wr)
                count <= count - (MAX_DEPTH_BITS+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ip_fixer_preprocess.sv
// Snoops packets entering ip_fixer and queues one {new length, new checksum, is_ip}
// entry per packet. Define IP_FIXER_HDR_CHECK_EN to also verify the original header checksum.
module ip_fixer_preprocess
    import ip_fixer_pkg::*;
#(
    parameter int         DATA_WIDTH          = 64,
    parameter int         CTRL_WIDTH          = DATA_WIDTH/8,
    parameter logic [7:0] IOQ_CTRL            = 8'hFF,
    parameter int         ETH_HDR_LEN         = 14,
    parameter int         RES_FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [15:0]           new_ip_length,
    output logic [15:0]           new_ip_checksum,
    output logic                  pkt_is_ip,
    output logic                  new_data_avail,
    input  logic                  new_data_rd_en
);
    localparam int ENTRY_W = 33;

    state_t             state, state_nxt;
    logic               hdr_seen, is_ip, eop, push;
    logic [15:0]        byte_len, old_len, new_len, csum_w3;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               fifo_full, fifo_empty;
    logic               unused_in_data;

    assign unused_in_data = ^in_data;
    assign eop = (in_ctrl != '0);

    // RFC1624 eqn 3: HC' = ~(~HC + ~m + m')
    assign csum_w3 = ~ones_add16(ones_add16(~in_data[IP_CSUM_LSB +: 16], ~old_len), new_len);

`ifdef IP_FIXER_HDR_CHECK_EN
    logic [15:0] hdr_sum, hdr_sum_final, csum_hold;

    function automatic logic [15:0] add_halves(input logic [15:0] acc, input logic [63:0] w);
        return ones_add16(ones_add16(acc, w[63:48]),
                          ones_add16(ones_add16(w[47:32], w[31:16]), w[15:0]));
    endfunction

    assign hdr_sum_final = ones_add16(hdr_sum, in_data[DST_IP_LO_LSB +: 16]);
`endif

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_entry = '0;
        if (in_wr) begin
            case (state)
                MOD_HDR:  if (!eop) state_nxt = W1;
                W1: begin
                    if (eop) begin push = 1'b1; state_nxt = MOD_HDR; end
                    else state_nxt = W2;
                end
                W2: begin
                    if (eop) begin push = 1'b1; state_nxt = MOD_HDR; end
                    else state_nxt = W3;
                end
                W3: begin
                    if (eop) begin push = 1'b1; state_nxt = MOD_HDR; end
                    else begin
`ifdef IP_FIXER_HDR_CHECK_EN
                        state_nxt = W4;
`else
                        push       = 1'b1;
                        push_entry = {new_len, csum_w3, is_ip};
                        state_nxt  = WAIT_EOP;
`endif
                    end
                end
`ifdef IP_FIXER_HDR_CHECK_EN
                W4: begin
                    push = 1'b1;
                    if (eop) state_nxt = MOD_HDR;
                    else begin
                        push_entry = {new_len, csum_hold, is_ip && (hdr_sum_final == 16'hFFFF)};
                        state_nxt  = WAIT_EOP;
                    end
                end
`endif
                WAIT_EOP: if (eop) state_nxt = MOD_HDR;
                default:  state_nxt = MOD_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MOD_HDR;
            hdr_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_wr) begin
                if (state == MOD_HDR && in_ctrl == IOQ_CTRL) hdr_seen <= 1'b1;
                else if (state != MOD_HDR && eop)            hdr_seen <= 1'b0;
            end
        end
    end

    // Header field capture; state gating makes a reset of these unnecessary.
    always_ff @(posedge clk) begin
        if (in_wr) begin
            if (state == MOD_HDR && in_ctrl == IOQ_CTRL)
                byte_len <= in_data[BYTE_LEN_LSB +: 16];
            if (state == W1)
                is_ip <= hdr_seen && (in_data[ETHERTYPE_LSB +: 16] == ETHERTYPE_IP)
                                  && (in_data[VERSION_LSB +: 4] == IP_VERSION4);
            if (state == W2) begin
                old_len <= in_data[IP_LEN_LSB +: 16];
                new_len <= byte_len - 16'(ETH_HDR_LEN);
            end
`ifdef IP_FIXER_HDR_CHECK_EN
            if (state == W1) hdr_sum <= in_data[15:0];
            if (state == W2 || state == W3) hdr_sum <= add_halves(hdr_sum, in_data);
            if (state == W3) csum_hold <= csum_w3;
`endif
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (ENTRY_W),
        .MAX_DEPTH_BITS (RES_FIFO_DEPTH_BITS)
    ) u_res_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (push_entry),
        .wr_en (push),
        .rd_en (new_data_rd_en),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_rdy         = !fifo_full;
    assign new_data_avail = !fifo_empty;
    assign {new_ip_length, new_ip_checksum, pkt_is_ip} = fifo_empty ? '0 : head_entry;

endmodule

// File: tb/tb_ip_fixer_preprocess.sv
// Bench for ip_fixer_preprocess: builds packets with real IPv4 headers and checks
// result entries against a field-level model of length, RFC1624 checksum and is_ip.
module tb_ip_fixer_preprocess;

`ifdef IP_FIXER_HDR_CHECK_EN
    localparam int PUSH_W    = 4;
    localparam bit HDR_CHECK = 1'b1;
`else
    localparam int PUSH_W    = 3;
    localparam bit HDR_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [15:0] new_ip_length, new_ip_checksum;
    logic        pkt_is_ip, new_data_avail;
    logic        new_data_rd_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [71:0] pkt_q[$];
    logic [32:0] exp_q[$];
    int          push_idx;
    logic [32:0] pkt_exp;
    logic [15:0] last_byte_len;

    always #5 clk = ~clk;

    ip_fixer_preprocess dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .new_ip_length   (new_ip_length),
        .new_ip_checksum (new_ip_checksum),
        .pkt_is_ip       (pkt_is_ip),
        .new_data_avail  (new_data_avail),
        .new_data_rd_en  (new_data_rd_en)
    );

    function automatic logic [15:0] fold(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        while ((t >> 16) != 0) t = (t & 32'hFFFF) + (t >> 16);
        return t[15:0];
    endfunction

    // Builds the word list of one packet plus its expected result entry.
    task automatic build_pkt(input bit ioq, input logic [15:0] byte_len, input logic [15:0] eth,
                             input logic [3:0] ver, input logic [15:0] old_len,
                             input logic [15:0] old_csum, input bit corrupt, input int eop_w);
        logic [15:0] h[10];
        logic [63:0] w[6];
        logic [31:0] s;
        logic [15:0] nl, nc, noc, nol;
        bit          hdr_ok, ip;
        int          base;
        h[0] = {ver, 4'h5, 8'h00};
        h[1] = old_len;
        h[2] = 16'h0000;
        h[3] = 16'($urandom);
        h[4] = 16'($urandom);
        h[5] = old_csum;
        for (int i = 6; i < 10; i++) h[i] = 16'($urandom);
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0, h[i]};
        h[2] = ~fold(s);
        if (corrupt) h[5] = h[5] ^ 16'h0001;
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0, h[i]};
        hdr_ok = (fold(s) == 16'hFFFF);

        w[0] = {$urandom, $urandom};
        w[1] = {32'($urandom), eth, h[0]};
        w[2] = {h[1], h[2], h[3], h[4]};
        w[3] = {h[5], h[6], h[7], h[8]};
        w[4] = {h[9], 48'({$urandom, $urandom})};
        w[5] = {$urandom, $urandom};

        pkt_q.delete();
        base = 0;
        if (ioq) begin
            pkt_q.push_back({8'hFF, 48'({$urandom, $urandom}), byte_len});
            last_byte_len = byte_len;
            base = 1;
        end
        for (int i = 0; i <= eop_w; i++)
            pkt_q.push_back({(i == eop_w) ? 8'h80 : 8'h00, w[i]});

        nl  = last_byte_len - 16'd14;
        noc = ~h[5];
        nol = ~old_len;
        nc  = ~fold({16'h0, noc} + {16'h0, nol} + {16'h0, nl});
        ip  = ioq && (eth == 16'h0800) && (ver == 4'd4) && (hdr_ok || !HDR_CHECK);
        if (eop_w >= 1 && eop_w <= PUSH_W) begin
            pkt_exp  = '0;
            push_idx = base + eop_w;
        end else begin
            pkt_exp  = {nl, nc, ip};
            push_idx = base + PUSH_W;
        end
    endtask

    task automatic send_pkt(input bit gaps, input int rd_at,
                            output logic [33:0] rd_obs, output logic [32:0] rd_exp);
        rd_obs = '0;
        rd_exp = '0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_ctrl = 8'($urandom);
                in_data = {$urandom, $urandom};
                in_wr   = 1'b0;
                @(posedge clk); #1;
            end
            if (i == rd_at) begin
                rd_obs = {new_data_avail, new_ip_length, new_ip_checksum, pkt_is_ip};
                if (exp_q.size() > 0) rd_exp = exp_q.pop_front();
                new_data_rd_en = 1'b1;
            end
            in_ctrl = pkt_q[i][71:64];
            in_data = pkt_q[i][63:0];
            in_wr   = 1'b1;
            @(posedge clk); #1;
            in_wr = 1'b0;
            new_data_rd_en = 1'b0;
            if (i == push_idx && exp_q.size() < 4) exp_q.push_back(pkt_exp);
        end
    endtask

    task automatic pop_entry(output logic [33:0] obs);
        obs = {new_data_avail, new_ip_length, new_ip_checksum, pkt_is_ip};
        new_data_rd_en = 1'b1;
        @(posedge clk); #1;
        new_data_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        exp_q.delete();
        n_cmp++;
        if (new_data_avail !== 1'b0) begin
            n_err++; $display("FAIL reset_avail: got %b expected 0", new_data_avail);
        end
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy);
        end
        n_cmp++;
        if ({new_ip_length, new_ip_checksum, pkt_is_ip} !== 33'd0) begin
            n_err++; $display("FAIL reset_entry: got %h expected 0", {new_ip_length, new_ip_checksum, pkt_is_ip});
        end
        new_data_rd_en = 1'b1;
        idle(1);
        new_data_rd_en = 1'b0;
        n_cmp++;
        if ({new_data_avail, in_rdy} !== 2'b01) begin
            n_err++; $display("FAIL pop_empty: got avail/rdy %b expected 01", {new_data_avail, in_rdy});
        end
    endtask

    task automatic test_known_ip();
        logic [33:0] obs;
        build_pkt(1'b1, 16'd74, 16'h0800, 4'd4, 16'h0030, 16'hB1E6, 1'b0, 5);
        for (int i = 0; i < pkt_q.size(); i++) begin
            in_ctrl = pkt_q[i][71:64];
            in_data = pkt_q[i][63:0];
            in_wr   = 1'b1;
            @(posedge clk); #1;
            in_wr = 1'b0;
            if (i == push_idx - 1) begin
                n_cmp++;
                if (new_data_avail !== 1'b0) begin
                    n_err++; $display("FAIL known_avail_early: got %b expected 0", new_data_avail);
                end
            end
            if (i == push_idx) begin
                n_cmp++;
                if (new_data_avail !== 1'b1) begin
                    n_err++; $display("FAIL known_avail_after_push: got %b expected 1", new_data_avail);
                end
            end
        end
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, 16'h003C, 16'hB1DA, 1'b1}) begin
            n_err++; $display("FAIL known_ip_entry: got %h expected %h", obs, {1'b1, 16'h003C, 16'hB1DA, 1'b1});
        end
    endtask

    task automatic test_non_ip();
        logic [33:0] obs;
        logic [32:0] rexp;
        build_pkt(1'b1, 16'd60, 16'h0806, 4'd4, 16'($urandom), 16'($urandom), 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, exp_q.pop_front()} || obs[0] !== 1'b0) begin
            n_err++; $display("FAIL non_ip_entry: got %h expected %h", obs, {1'b1, pkt_exp});
        end
        n_cmp++;
        if (new_data_avail !== 1'b0) begin
            n_err++; $display("FAIL non_ip_single_entry: avail got %b expected 0", new_data_avail);
        end
    endtask

    task automatic test_unchanged_csum();
        logic [33:0] obs;
        logic [32:0] rexp;
        build_pkt(1'b1, 16'd60, 16'h0800, 4'd4, 16'h002E, 16'h1234, 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        exp_q.delete();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, 16'h002E, 16'h1234, 1'b1}) begin
            n_err++; $display("FAIL unchanged_csum: got %h expected %h", obs, {1'b1, 16'h002E, 16'h1234, 1'b1});
        end
    endtask

    task automatic test_fill_and_drain();
        logic [33:0] obs;
        logic [32:0] rexp;
        logic [32:0] exp;
        for (int p = 0; p < 4; p++) begin
            build_pkt(1'b1, 16'($urandom_range(60, 1514)), 16'h0800, 4'd4, 16'($urandom),
                      16'($urandom), 1'b0, 5);
            send_pkt(1'b0, -1, obs, rexp);
            n_cmp++;
            if (in_rdy !== (p < 3)) begin
                n_err++; $display("FAIL fill_in_rdy[%0d]: got %b expected %b", p, in_rdy, p < 3);
            end
        end
        exp = exp_q.pop_front();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, exp}) begin
            n_err++; $display("FAIL fill_pop0: got %h expected %h", obs, {1'b1, exp});
        end
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_err++; $display("FAIL in_rdy_after_pop: got %b expected 1", in_rdy);
        end
        build_pkt(1'b1, 16'($urandom_range(60, 1514)), 16'h0800, 4'd4, 16'($urandom),
                  16'($urandom), 1'b0, 5);
        send_pkt(1'b0, push_idx, obs, rexp);
        n_cmp++;
        if (obs !== {1'b1, rexp}) begin
            n_err++; $display("FAIL push_pop_head: got %h expected %h", obs, {1'b1, rexp});
        end
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_err++; $display("FAIL push_pop_count: in_rdy got %b expected 1", in_rdy);
        end
        build_pkt(1'b1, 16'($urandom_range(60, 1514)), 16'h0800, 4'd4, 16'($urandom),
                  16'($urandom), 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_err++; $display("FAIL refill_in_rdy: got %b expected 0", in_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
            pop_entry(obs);
            n_cmp++;
            if (obs !== {1'b1, exp}) begin
                n_err++; $display("FAIL drain[%0d]: got %h expected %h", k, obs, {1'b1, exp});
            end
        end
        n_cmp++;
        if ({new_data_avail, in_rdy} !== 2'b01) begin
            n_err++; $display("FAIL drained_state: got avail/rdy %b expected 01", {new_data_avail, in_rdy});
        end
    endtask

    task automatic test_short_pkt();
        logic [33:0] obs;
        logic [32:0] rexp;
        logic [32:0] exp;
        build_pkt(1'b1, 16'd98, 16'h0800, 4'd4, 16'h0054, 16'($urandom), 1'b0, 2);
        send_pkt(1'b0, -1, obs, rexp);
        build_pkt(1'b1, 16'd74, 16'h0800, 4'd4, 16'h0030, 16'hB1E6, 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        exp = exp_q.pop_front();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, exp} || obs[0] !== 1'b0) begin
            n_err++; $display("FAIL short_entry: got %h expected %h", obs, {1'b1, exp});
        end
        exp = exp_q.pop_front();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, 16'h003C, 16'hB1DA, 1'b1}) begin
            n_err++; $display("FAIL after_short_entry: got %h expected %h", obs, {1'b1, 16'h003C, 16'hB1DA, 1'b1});
        end
    endtask

    task automatic test_corrupt_csum();
        logic [33:0] obs;
        logic [32:0] rexp;
        logic [32:0] exp;
        build_pkt(1'b1, 16'd74, 16'h0800, 4'd4, 16'h0030, 16'hB1E6, 1'b1, 5);
        send_pkt(1'b0, -1, obs, rexp);
        exp = exp_q.pop_front();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, exp}) begin
            n_err++; $display("FAIL corrupt_csum_entry: got %h expected %h", obs, {1'b1, exp});
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [33:0] obs;
        logic [32:0] rexp;
        logic [32:0] exp;
        build_pkt(1'b1, 16'd300, 16'h0800, 4'd4, 16'($urandom), 16'($urandom), 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        build_pkt(1'b1, 16'd400, 16'h0800, 4'd4, 16'($urandom), 16'($urandom), 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            in_ctrl = pkt_q[i][71:64];
            in_data = pkt_q[i][63:0];
            in_wr   = 1'b1;
            @(posedge clk); #1;
            in_wr = 1'b0;
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        n_cmp++;
        if ({new_data_avail, in_rdy, new_ip_length, new_ip_checksum, pkt_is_ip} !== {2'b01, 33'd0}) begin
            n_err++; $display("FAIL reset_mid_packet: got %h expected %h",
                              {new_data_avail, in_rdy, new_ip_length, new_ip_checksum, pkt_is_ip}, {2'b01, 33'd0});
        end
        build_pkt(1'b1, 16'($urandom_range(60, 1514)), 16'h0800, 4'd4, 16'($urandom),
                  16'($urandom), 1'b0, 5);
        send_pkt(1'b0, -1, obs, rexp);
        exp = exp_q.pop_front();
        pop_entry(obs);
        n_cmp++;
        if (obs !== {1'b1, exp} || obs[0] !== 1'b1) begin
            n_err++; $display("FAIL after_reset_entry: got %h expected %h", obs, {1'b1, exp});
        end
    endtask

    task automatic test_random();
        logic [33:0] obs;
        logic [32:0] rexp;
        logic [32:0] exp;
        for (int p = 0; p < 24; p++) begin
            build_pkt(($urandom_range(0, 5) != 0),
                      16'($urandom_range(60, 1514)),
                      ($urandom_range(0, 3) == 0) ? 16'h0806 : 16'h0800,
                      ($urandom_range(0, 4) == 0) ? 4'd6 : 4'd4,
                      16'($urandom), 16'($urandom),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 5);
            send_pkt(1'b1, -1, obs, rexp);
            idle($urandom_range(0, 2));
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                pop_entry(obs);
                n_cmp++;
                if (obs !== {1'b1, exp}) begin
                    n_err++; $display("FAIL random_pkt[%0d]: got %h expected %h", p, obs, {1'b1, exp});
                end
            end
            n_cmp++;
            if (new_data_avail !== 1'b0) begin
                n_err++; $display("FAIL random_extra_entry[%0d]: avail got %b expected 0", p, new_data_avail);
            end
        end
    endtask

    initial begin
        #1;
        last_byte_len = 16'd60;
        test_reset();
        test_known_ip();
        test_non_ip();
        test_unchanged_csum();
        test_fill_and_drain();
        test_short_pkt();
        test_corrupt_csum();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
